// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Tag/data live in inferred RAM with a registered read; valid bits are flops so flush/reset clear them in one edge.
module dcache #(
  parameter int LINES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        flush,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt,
  output logic [1:0]  state
);

  localparam int IDX   = $clog2(LINES);
  localparam int TAG_W = 30 - IDX;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    FILL    = 2'd2,
    WRITE   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic              we_q, we_d;
  logic [29:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              hit_q, hit_d;

  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [15:0]       hit_cnt_q, hit_cnt_d;
  logic [15:0]       miss_cnt_q, miss_cnt_d;

  logic [LINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]  tag_mem [LINES];
  logic [31:0]       data_mem [LINES];
  logic [TAG_W-1:0]  rd_tag_q;
  logic [31:0]       rd_data_q;

  logic              flush_all;
  logic              fill_en;
  logic              line_wr_en;
  logic [31:0]       line_wdata;
  logic              rd_en;

  logic [IDX-1:0]    req_idx;
  logic [IDX-1:0]    idx_w;
  logic [TAG_W-1:0]  tag_w;
  logic              lookup_hit;
  logic              unused_addr_bits;

  assign req_idx          = cpu_addr[IDX+1:2];
  assign idx_w            = addr_q[IDX-1:0];
  assign tag_w            = addr_q[29:IDX];
  assign lookup_hit       = valid_q[idx_w] && (rd_tag_q == tag_w);
  assign unused_addr_bits = ^cpu_addr[1:0];

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    hit_d       = hit_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ready_d = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    flush_all   = 1'b0;
    fill_en     = 1'b0;
    line_wr_en  = 1'b0;
    line_wdata  = '0;
    rd_en       = 1'b0;

    case (state_q)
      IDLE: begin
        if (flush) begin
          flush_all = 1'b1;
        end else if (cpu_req) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr[31:2];
          wdata_d = cpu_wdata;
          rd_en   = 1'b1;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        hit_d = lookup_hit;
        if (lookup_hit) hit_cnt_d = sat_inc(hit_cnt_q);
        else            miss_cnt_d = sat_inc(miss_cnt_q);
        if (we_q) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = {addr_q, 2'b00};
          mem_wdata_d = wdata_q;
          state_d     = WRITE;
        end else if (lookup_hit) begin
          cpu_rdata_d = rd_data_q;
          cpu_ready_d = 1'b1;
          state_d     = IDLE;
        end else begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = {addr_q, 2'b00};
          state_d    = FILL;
        end
      end
      FILL: begin
        if (mem_ack) begin
          fill_en     = 1'b1;
          line_wr_en  = 1'b1;
          line_wdata  = mem_rdata;
          cpu_rdata_d = mem_rdata;
          cpu_ready_d = 1'b1;
          mem_req_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          // Write-through: only a line that already holds this address is updated.
          line_wr_en  = hit_q;
          line_wdata  = wdata_q;
          cpu_ready_d = 1'b1;
          mem_req_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < LINES; gi++) begin : g_valid
      assign valid_d[gi] = flush_all ? 1'b0 :
                           (fill_en && (idx_w == IDX'(gi))) ? 1'b1 : valid_q[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      hit_q       <= 1'b0;
      cpu_rdata_q <= '0;
      cpu_ready_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      hit_q       <= hit_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ready_q <= cpu_ready_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      valid_q     <= valid_d;
    end
  end

  // Reset at the ack edge must not let an aborted fill or write land in the array.
  always_ff @(posedge clk) begin
    if (line_wr_en && !rst) begin
      data_mem[idx_w] <= line_wdata;
      if (fill_en) tag_mem[idx_w] <= tag_w;
    end
    if (rd_en) begin
      rd_tag_q  <= tag_mem[req_idx];
      rd_data_q <= data_mem[req_idx];
    end
  end

  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ready = cpu_ready_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;
  assign state     = state_q;

endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 Parameter: LINES, default 16, number of direct-mapped one-word lines (power of two, 2..256).
REQ-002 The block SHALL have one clock, clk; reset rst is synchronous and active-high.
REQ-003 Ports SHALL be, in this order:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- cpu_req  in  1  CPU access request, held until cpu_ready
- cpu_we  in  1  1=store, 0=load
- cpu_addr  in  32  byte address, [1:0] ignored
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data, valid while cpu_ready=1
- cpu_ready  out  1  one-cycle completion pulse
- flush  in  1  invalidate all lines
- mem_req  out  1  backing-memory request
- mem_we  out  1  backing write
- mem_addr  out  32  word-aligned address ([1:0]=0)
- mem_wdata  out  32  backing write data
- mem_rdata  in  32  backing read data, valid with mem_ack
- mem_ack  in  1  backing completion, one cycle
- hit_cnt  out  16  hit counter
- miss_cnt  out  16  miss counter
- state  out  2  FSM state (debug)

Function
REQ-004 Address split: index = cpu_addr[IDX+1:2] with IDX = log2(LINES); tag = cpu_addr[31:IDX+2]. Each line holds a valid bit, a tag and 32 data bits.
REQ-005 The FSM SHALL have four states: IDLE=0, COMPARE=1, FILL=2, WRITE=3. All outputs SHALL be registered.
REQ-006 IDLE with flush=1 SHALL clear every valid bit at that edge and stay in IDLE. Flush has priority over cpu_req, and the request is not accepted that cycle.
REQ-007 IDLE with cpu_req=1 and flush=0 SHALL latch addr/we/wdata and go to COMPARE. The CPU holds its inputs stable until cpu_ready.
REQ-008 COMPARE with a read hit (valid and tag match) SHALL set cpu_rdata=line data and cpu_ready=1, then go to IDLE. Hit latency is 2 cycles from the cycle cpu_req is sampled to the cpu_ready cycle.
REQ-009 COMPARE with a read miss SHALL set mem_req=1, mem_we=0, mem_addr={addr[31:2],2'b00}, then go to FILL.
REQ-010 FILL with mem_ack=1 SHALL, at that edge:
- write valid=1, tag and data=mem_rdata into the line;
- set cpu_rdata=mem_rdata, cpu_ready=1, mem_req=0;
- go to IDLE.
REQ-011 COMPARE with a write (hit or miss) SHALL set mem_req=1, mem_we=1, mem_addr as in REQ-009, mem_wdata=latched wdata, then go to WRITE.
REQ-012 WRITE with mem_ack=1 SHALL set cpu_ready=1 and mem_req=0, then go to IDLE. On a write hit it SHALL also update the line data at that edge. A write miss SHALL NOT allocate.
REQ-013 mem_req, mem_we, mem_addr and mem_wdata SHALL stay constant from assertion until the edge that samples mem_ack. mem_ack SHALL be ignored in IDLE and COMPARE.
REQ-014 cpu_ready SHALL be high for exactly one cycle per accepted request and zero otherwise. cpu_rdata holds its last value when cpu_ready=0, and is unchanged by writes.
REQ-015 cpu_req and flush SHALL be ignored outside IDLE. A cpu_req still high in the cpu_ready cycle (state=IDLE) SHALL be accepted as a new request.
REQ-016 The counters SHALL update at the COMPARE edge only:
- hit_cnt += 1 on a hit (read or write);
- miss_cnt += 1 on a miss;
- both saturate at 16'hFFFF and do not wrap.

Reset
REQ-017 rst=1 at any edge, in any state (including FILL/WRITE mid-transaction), SHALL:
- set state=IDLE;
- clear all valid bits;
- set cpu_ready=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, hit_cnt=0, miss_cnt=0.
REQ-018 A fill aborted by reset SHALL NOT write any line. A mem_ack arriving after reset SHALL be ignored.

Verification
REQ-019 Read miss then hit:
- Load 0x40, memory acks 3 cycles after mem_req with 0xDEADBEEF -> cpu_rdata=0xDEADBEEF, miss_cnt=1.
- Repeat load 0x40 -> cpu_ready 2 cycles after cpu_req, no mem_req, hit_cnt=1.
REQ-020 Conflict (LINES=16): load 0x40 then load 0x80 (same index 0, different tag) -> both miss. Reload 0x40 -> miss, miss_cnt=3.
REQ-021 Write-through:
- Store 0x12345678 to cached 0x40 -> mem_we=1, mem_wdata=0x12345678; the next load of 0x40 hits and returns 0x12345678.
- Store to uncached 0x44 -> no allocate; the next load of 0x44 misses.
REQ-022 Flush: with 0x40 cached, assert flush and cpu_req together in IDLE -> request not accepted that cycle; the subsequent load of 0x40 misses.
REQ-023 Reset mid-fill: rst during FILL before mem_ack -> mem_req=0 next cycle, a late mem_ack is ignored, counters=0, and the next load of the same address misses.
REQ-024 Saturation: force miss_cnt to 0xFFFF and issue one miss -> miss_cnt stays 0xFFFF.
